tlc_phase_sequencer: RTL and testbench
======================================

Name: tlc_phase_sequencer

Overview:
- Clocked phase sequencer for a two-road intersection. Road 1 is the highway; road 2 is the farm road.
- Drives the GRN/YLW/RED lamp set for each road from a registered phase FSM with a shared down-counting phase timer and a tick prescaler.
- Arbitrates farm-road sensor requests against the highway minimum-green time.
- Supports a test-speed mode and a flash (fail-safe) mode.
- Sits above the lamp-latch/counter datapath and replaces its ad-hoc counter sequencing.

Parameters:
- TICK_DIV, 1000: clock cycles per timer tick in normal mode (>=2).
- TW, 8: phase timer width in bits.
- HG_MIN, 25: highway minimum green, in ticks.
- Y_TIME, 4: yellow duration, in ticks, both roads.
- AR_TIME, 2: all-red clearance duration, in ticks.
- FG_MIN, 5: farm minimum green, in ticks.
- FG_MAX, 25: farm maximum green, in ticks. FG_MIN <= FG_MAX < 2^TW.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous clear; same effect as reset, on the next edge.
- TEST  in  1  1 = one tick per clock (prescaler bypassed).
- FM  in  1  flash-mode request.
- FARM_SNS  in  1  farm-road vehicle sensor, synchronous, level.
- GRN1, YLW1, RED1  out  1 each  highway lamps.
- GRN2, YLW2, RED2  out  1 each  farm lamps.
- PHASE  out  3  current FSM state encoding.
- TICK  out  1  internal tick strobe, for observability.

Behaviour:
- Reset (RST_N low, asynchronous) and CLR (synchronous): state = AR0, timer = AR_TIME-1, prescaler = 0, req = 0, lamps RED1 = RED2 = 1 and all others 0, TICK = 0.
- Prescaler: counts 0..TICK_DIV-1. TICK is 1 for one cycle when the count is TICK_DIV-1. With TEST = 1, TICK = 1 every cycle and the prescaler is held at 0.
- Timer: loaded with D-1 on entry to a state of duration D. Decrements on TICK. Expiry = TICK && timer == 0, so a state lasts exactly D ticks. No wrap: the timer holds at 0.
- req: set on any cycle with FARM_SNS = 1. Cleared on entry to FG; a set and a clear in the same cycle resolve to clear.
- States and encoding: AR0 = 0, HG = 1, HY = 2, AR1 = 3, FG = 4, FY = 5, AR2 = 6, FLASH = 7.
- AR0 -> HG on expiry. Load HG_MIN-1.
- HG -> HY when timer == 0 && req, sampled on TICK. HG holds indefinitely without req. Load Y_TIME-1.
- HY -> AR1 on expiry. Load AR_TIME-1.
- AR1 -> FG on expiry. Load FG_MAX-1.
- FG -> FY on expiry, or on TICK when FARM_SNS == 0 && timer <= FG_MAX-FG_MIN. Load Y_TIME-1.
- FY -> AR2 on expiry. Load AR_TIME-1.
- AR2 -> HG on expiry. Load HG_MIN-1.
- FM = 1 is honoured only in AR0, AR1 or AR2, on that state's expiry; it overrides the normal exit and goes to FLASH. FM raised in a green or yellow state completes that state's normal path to the next all-red state first.
- FLASH: YLW1 and RED2 toggle on each TICK, starting at 1; all other lamps are 0. When FM = 0 is seen on TICK: go to AR0 and load AR_TIME-1.
- Lamps are registered and decoded from the next state, so the lamps change on the same edge as PHASE.
- Lamp decode:
  - HG: GRN1, RED2.
  - HY: YLW1, RED2.
  - FG: RED1, GRN2.
  - FY: RED1, YLW2.
  - AR*: RED1, RED2.
- Safety invariant: GRN or YLW is never asserted on both roads at once. Exactly one lamp per road is on, except in FLASH.

Optional Feature:
- Macro TLC_PED_EN.
- When defined:
  - Adds input PED_REQ (1) and output WALK (1, reset 0).
  - PED_REQ sets req exactly as FARM_SNS does.
  - WALK = 1 throughout FG and 0 elsewhere, registered like the lamps.
  - FG early exit additionally requires that no PED_REQ has been seen since FG entry.
- When undefined: ports absent; behaviour exactly as above.

Test Plan:
- Reset/startup: TEST = 1, RST_N pulsed low mid-HG with all inputs 0 -> lamps immediately RED1/RED2, PHASE = 0; after 2 clocks PHASE = 1 and GRN1 = 1, holding indefinitely.
- Full cycle: TEST = 1, FARM_SNS = 1 for 1 cycle at cycle 3 -> HG ends at cycle 27. Durations HY 4, AR1 2, FG 25 (with FARM_SNS held 1), FY 4, AR2 2 clocks; then HG. At no cycle are both GRN1 and GRN2 asserted.
- Early farm exit: FARM_SNS = 1 through 7 FG ticks, then 0 -> FY entered on the 8th FG tick, i.e. after 7 FG ticks (limit is FG_MIN = 5).
- Flash: FM = 1 asserted in HG with req pending -> the HY/AR1 path completes, then FLASH with YLW1/RED2 toggling every clock. FM = 0 -> AR0 for 2 clocks, then HG.
- Prescaler: TEST = 0, TICK_DIV = 4 -> TICK every 4th clock; an HY of 4 ticks lasts 16 clocks.
- CLR asserted in FG -> next edge gives PHASE = 0, RED1/RED2 lamps, req = 0.

Source files
------------

// File: rtl/tlc_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tlc_phase_sequencer
//
// Phase sequencer for a two-road intersection (road 1 = highway, road 2 =
// farm road). A registered phase FSM drives both lamp sets. One shared
// down-counting phase timer advances on a prescaled tick. Farm-road sensor
// requests are arbitrated against the highway minimum green. A flash
// (fail-safe) mode is entered only from an all-red clearance state.
//
// Ports:
//   CLK       in   system clock, rising edge
//   RST_N     in   asynchronous active-low reset
//   CLR       in   synchronous clear (same effect as reset, next edge)
//   TEST      in   1 = one tick per clock, prescaler held at 0
//   FM        in   flash-mode request
//   FARM_SNS  in   farm-road vehicle sensor (synchronous level)
//   PED_REQ   in   pedestrian request (only with TLC_PED_EN)
//   WALK      out  walk lamp, on throughout FG (only with TLC_PED_EN)
//   GRN1/YLW1/RED1  out  highway lamps (registered)
//   GRN2/YLW2/RED2  out  farm lamps (registered)
//   PHASE     out  current FSM state encoding
//   TICK      out  internal tick strobe
//
// Optional feature: define TLC_PED_EN to add the pedestrian request input
// and the WALK output.
// -----------------------------------------------------------------------------
module tlc_phase_sequencer #(
    parameter int TICK_DIV = 1000,
    parameter int TW       = 8,
    parameter int HG_MIN   = 25,
    parameter int Y_TIME   = 4,
    parameter int AR_TIME  = 2,
    parameter int FG_MIN   = 5,
    parameter int FG_MAX   = 25
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CLR,
    input  logic       TEST,
    input  logic       FM,
    input  logic       FARM_SNS,
`ifdef TLC_PED_EN
    input  logic       PED_REQ,
    output logic       WALK,
`endif
    output logic       GRN1,
    output logic       YLW1,
    output logic       RED1,
    output logic       GRN2,
    output logic       YLW2,
    output logic       RED2,
    output logic [2:0] PHASE,
    output logic       TICK
);

    typedef enum logic [2:0] {
        ST_AR0   = 3'd0,
        ST_HG    = 3'd1,
        ST_HY    = 3'd2,
        ST_AR1   = 3'd3,
        ST_FG    = 3'd4,
        ST_FY    = 3'd5,
        ST_AR2   = 3'd6,
        ST_FLASH = 3'd7
    } phase_e;

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] T_AR     = TW'(AR_TIME - 1);
    // FG may be cut short once at least FG_MIN ticks have elapsed, i.e. once
    // the remaining count has fallen to FG_MAX-FG_MIN.
    localparam logic [TW-1:0] FG_EARLY = TW'(FG_MAX - FG_MIN);
    // Lamp vector order: {GRN1, YLW1, RED1, GRN2, YLW2, RED2}.
    localparam logic [5:0]    LAMPS_AR = 6'b001_001;

    // Timer load value (duration-1) for the state being entered.
    function automatic logic [TW-1:0] load_for(input phase_e s);
        logic [TW-1:0] v;
        case (s)
            ST_HG:                  v = TW'(HG_MIN - 1);
            ST_HY, ST_FY:           v = TW'(Y_TIME - 1);
            ST_FG:                  v = TW'(FG_MAX - 1);
            ST_AR0, ST_AR1, ST_AR2: v = T_AR;
            default:                v = {TW{1'b0}};
        endcase
        return v;
    endfunction

    // Lamp pattern for a state; in FLASH the blink phase drives YLW1/RED2.
    function automatic logic [5:0] lamp_decode(input phase_e s, input logic fl);
        logic [5:0] v;
        case (s)
            ST_HG:    v = 6'b100_001;
            ST_HY:    v = 6'b010_001;
            ST_FG:    v = 6'b001_100;
            ST_FY:    v = 6'b001_010;
            ST_FLASH: v = {1'b0, fl, 1'b0, 1'b0, 1'b0, fl};
            default:  v = LAMPS_AR;
        endcase
        return v;
    endfunction

    phase_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d, tmr_run_s;
    logic [PW-1:0] ps_q, ps_d;
    logic          req_q, req_d;
    logic          flash_q, flash_d;
    logic [5:0]    lamps_q, lamps_d;
    logic          tick_s, expire_s, fg_early_s, req_set_s, fg_entry_s;
`ifdef TLC_PED_EN
    logic          ped_seen_q, ped_seen_d;
    logic          walk_q, walk_d;
    logic          ped_block_s;
`endif

    // Tick prescaler: wraps at TICK_DIV-1, held at zero in test-speed mode.
    always_comb begin
        tick_s = TEST | (ps_q == PS_LAST);
        if (TEST) begin
            ps_d = {PW{1'b0}};
        end else if (ps_q == PS_LAST) begin
            ps_d = {PW{1'b0}};
        end else begin
            ps_d = ps_q + 1'b1;
        end
    end

    // Phase next-state, timer, request latch and lamp decode.
    always_comb begin
        expire_s = tick_s && (tmr_q == {TW{1'b0}});
`ifdef TLC_PED_EN
        ped_block_s = ped_seen_q | PED_REQ;
        req_set_s   = FARM_SNS | PED_REQ;
        fg_early_s  = tick_s && !FARM_SNS && (tmr_q <= FG_EARLY) && !ped_block_s;
`else
        req_set_s   = FARM_SNS;
        fg_early_s  = tick_s && !FARM_SNS && (tmr_q <= FG_EARLY);
`endif
        state_d = state_q;
        case (state_q)
            ST_AR0: begin
                if (expire_s) state_d = FM ? ST_FLASH : ST_HG;
                else          state_d = state_q;
            end
            ST_HG: begin
                // HG only ends at its minimum when a request is pending.
                if (expire_s && req_q) state_d = ST_HY;
                else                   state_d = state_q;
            end
            ST_HY: begin
                if (expire_s) state_d = ST_AR1;
                else          state_d = state_q;
            end
            ST_AR1: begin
                if (expire_s) state_d = FM ? ST_FLASH : ST_FG;
                else          state_d = state_q;
            end
            ST_FG: begin
                if (expire_s || fg_early_s) state_d = ST_FY;
                else                        state_d = state_q;
            end
            ST_FY: begin
                if (expire_s) state_d = ST_AR2;
                else          state_d = state_q;
            end
            ST_AR2: begin
                if (expire_s) state_d = FM ? ST_FLASH : ST_HG;
                else          state_d = state_q;
            end
            ST_FLASH: begin
                if (tick_s && !FM) state_d = ST_AR0;
                else               state_d = state_q;
            end
            default: state_d = ST_AR0;
        endcase

        // Timer counts down on ticks and saturates at zero; reload on entry.
        tmr_run_s = (tick_s && (tmr_q != {TW{1'b0}})) ? (tmr_q - 1'b1) : tmr_q;
        tmr_d     = (state_d != state_q) ? load_for(state_d) : tmr_run_s;

        // Blink phase restarts lit on any state entry, toggles per FLASH tick.
        flash_d = (state_d != state_q) ? 1'b1 :
                  ((state_q == ST_FLASH) && tick_s) ? ~flash_q : flash_q;

        // Clear on FG entry wins over a simultaneous set.
        fg_entry_s = (state_d == ST_FG) && (state_q != ST_FG);
        req_d      = fg_entry_s ? 1'b0 : (req_q | req_set_s);

`ifdef TLC_PED_EN
        if (fg_entry_s)                        ped_seen_d = 1'b0;
        else if ((state_q == ST_FG) && PED_REQ) ped_seen_d = 1'b1;
        else                                   ped_seen_d = ped_seen_q;
        walk_d = (state_d == ST_FG);
`endif
        lamps_d = lamp_decode(state_d, flash_d);
    end

    // Phase FSM state, timer, prescaler, request latch and registered lamps.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_AR0;
            tmr_q      <= T_AR;
            ps_q       <= {PW{1'b0}};
            req_q      <= 1'b0;
            flash_q    <= 1'b1;
            lamps_q    <= LAMPS_AR;
`ifdef TLC_PED_EN
            ped_seen_q <= 1'b0;
            walk_q     <= 1'b0;
`endif
        end else if (CLR) begin
            state_q    <= ST_AR0;
            tmr_q      <= T_AR;
            ps_q       <= {PW{1'b0}};
            req_q      <= 1'b0;
            flash_q    <= 1'b1;
            lamps_q    <= LAMPS_AR;
`ifdef TLC_PED_EN
            ped_seen_q <= 1'b0;
            walk_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            ps_q       <= ps_d;
            req_q      <= req_d;
            flash_q    <= flash_d;
            lamps_q    <= lamps_d;
`ifdef TLC_PED_EN
            ped_seen_q <= ped_seen_d;
            walk_q     <= walk_d;
`endif
        end
    end

    assign {GRN1, YLW1, RED1, GRN2, YLW2, RED2} = lamps_q;
    assign PHASE = state_q;
    assign TICK  = tick_s;
`ifdef TLC_PED_EN
    assign WALK  = walk_q;
`endif

endmodule

// File: tb/tb_tlc_phase_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for tlc_phase_sequencer (default build, TICK_DIV = 4).
// A reference model tracks the phase by name, elapsed ticks in the phase and a
// prescaler count; per-cycle expected outputs are queued by the stimulus
// process and compared by an independent monitor after each rising edge.
// -----------------------------------------------------------------------------
module tb_tlc_phase_sequencer;

    localparam int TD    = 4;
    localparam int HGM   = 25;
    localparam int YT    = 4;
    localparam int ART   = 2;
    localparam int FGMIN = 5;
    localparam int FGMAX = 25;

    localparam int S_AR0 = 0, S_HG = 1, S_HY = 2, S_AR1 = 3;
    localparam int S_FG = 4, S_FY = 5, S_AR2 = 6, S_FLASH = 7;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       CLR = 1'b0;
    logic       TEST = 1'b0;
    logic       FM = 1'b0;
    logic       FARM_SNS = 1'b0;
    logic       GRN1, YLW1, RED1, GRN2, YLW2, RED2;
    logic [2:0] PHASE;
    logic       TICK;

    tlc_phase_sequencer #(.TICK_DIV(TD)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .TEST(TEST), .FM(FM),
        .FARM_SNS(FARM_SNS),
        .GRN1(GRN1), .YLW1(YLW1), .RED1(RED1),
        .GRN2(GRN2), .YLW2(YLW2), .RED2(RED2),
        .PHASE(PHASE), .TICK(TICK)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;
    logic [9:0] exp_q[$];
    wire  [9:0] act_s = {PHASE, GRN1, YLW1, RED1, GRN2, YLW2, RED2, TICK};

    // Reference model state
    int m_st, m_el, m_ps;
    bit m_req, m_fl;

    function automatic void model_reset();
        m_st = S_AR0; m_el = 0; m_ps = 0; m_req = 1'b0; m_fl = 1'b1;
    endfunction

    function automatic logic [9:0] model_out(input bit test);
        logic [5:0] l;
        case (m_st)
            S_HG:    l = 6'b100_001;
            S_HY:    l = 6'b010_001;
            S_FG:    l = 6'b001_100;
            S_FY:    l = 6'b001_010;
            S_FLASH: l = {1'b0, m_fl, 1'b0, 1'b0, 1'b0, m_fl};
            default: l = 6'b001_001;
        endcase
        return {3'(m_st), l, (test || (m_ps == TD - 1))};
    endfunction

    // One clock of the reference model: durations counted as elapsed ticks.
    function automatic void model_step(input bit sns, input bit fm, input bit test, input bit clr);
        bit tk;
        int nst;
        if (clr) begin
            model_reset();
            return;
        end
        tk   = test || (m_ps == TD - 1);
        m_ps = test ? 0 : (m_ps + 1) % TD;
        nst  = m_st;
        case (m_st)
            S_AR0, S_AR1, S_AR2:
                if (tk && (m_el + 1 == ART))
                    nst = fm ? S_FLASH : ((m_st == S_AR1) ? S_FG : S_HG);
            S_HG:  if (tk && (m_el + 1 >= HGM) && m_req) nst = S_HY;
            S_HY:  if (tk && (m_el + 1 == YT)) nst = S_AR1;
            S_FG:  if (tk && ((m_el + 1 == FGMAX) || (!sns && (m_el + 1 >= FGMIN)))) nst = S_FY;
            S_FY:  if (tk && (m_el + 1 == YT)) nst = S_AR2;
            default: begin
                if (tk) begin
                    if (fm) m_fl = !m_fl;
                    else    nst = S_AR0;
                end
            end
        endcase
        m_req = m_req | sns;
        if (nst == S_FG && m_st != S_FG) m_req = 1'b0;
        if (nst != m_st) begin
            m_el = 0;
            m_fl = 1'b1;
        end else if (tk && m_el < 1000) begin
            m_el++;
        end
        m_st = nst;
    endfunction

    function automatic void chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got phase=%0d lamps(G1Y1R1G2Y2R2)=%b tick=%b, expected phase=%0d lamps=%b tick=%b",
                     name, $time, act[9:7], act[6:1], act[0], exp[9:7], exp[6:1], exp[0]);
        end
    endfunction

    // Monitor: compare queued expectation after every rising edge.
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cycle", act_s, e);
            end
            n_total++;
            if ((GRN1 | YLW1) && (GRN2 | YLW2))
                $display("FAIL safety at %0t: both roads green/yellow, lamps=%b", $time, act_s[6:1]);
            else
                n_pass++;
        end
    end

    task automatic step(input bit sns, input bit fm, input bit test, input bit clr);
        @(negedge CLK);
        FARM_SNS = sns; FM = fm; TEST = test; CLR = clr;
        model_step(sns, fm, test, clr);
        exp_q.push_back(model_out(test));
    endtask

    task automatic run(input bit sns, input bit fm, input bit test, input int n);
        for (int i = 0; i < n; i++) step(sns, fm, test, 1'b0);
    endtask

    task automatic run_until(input int st, input bit sns, input bit fm, input bit test);
        int k;
        k = 0;
        while (m_st != st && k < 600) begin
            step(sns, fm, test, 1'b0);
            k++;
        end
        if (m_st != st) begin
            n_total++;
            $display("FAIL reach_state: state %0d not reached within 600 cycles (at %0d)", st, m_st);
        end
    endtask

    // Asynchronous reset pulse checked immediately, then one driven cycle.
    task automatic do_reset(input bit test);
        @(negedge CLK);
        RST_N = 1'b0; CLR = 1'b0; FM = 1'b0; FARM_SNS = 1'b0; TEST = test;
        #1;
        model_reset();
        chk("async_reset", act_s, model_out(test));
        @(negedge CLK);
        RST_N = 1'b1;
        model_step(1'b0, 1'b0, test, 1'b0);
        exp_q.push_back(model_out(test));
    endtask

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r_fm, r_test;
        model_reset();

        // Startup reset and mid-HG reset, then HG holds without requests.
        do_reset(1'b0);
        run(1'b0, 1'b0, 1'b1, 10);
        do_reset(1'b1);
        run(1'b0, 1'b0, 1'b1, 40);

        // Full cycle: single sensor pulse at cycle 3, sensor held through FG.
        do_reset(1'b1);
        run(1'b0, 1'b0, 1'b1, 3);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        run(1'b0, 1'b0, 1'b1, 24);
        run(1'b1, 1'b0, 1'b1, 40);
        run(1'b0, 1'b0, 1'b1, 5);

        // Early farm exit after 7 occupied FG ticks.
        run_until(S_FG, 1'b1, 1'b0, 1'b1);
        run(1'b1, 1'b0, 1'b1, 7);
        run(1'b0, 1'b0, 1'b1, 12);

        // Flash requested in HG with a request pending.
        run_until(S_HG, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        run(1'b0, 1'b1, 1'b1, 60);
        run(1'b0, 1'b0, 1'b1, 10);

        // Prescaled operation.
        run(1'b1, 1'b0, 1'b0, 250);

        // Synchronous clear in FG; request must be forgotten (HG then holds).
        run_until(S_FG, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        run(1'b0, 1'b0, 1'b1, 40);

        // Randomized traffic.
        r_fm = 1'b0;
        r_test = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) r_fm = !r_fm;
            if ($urandom_range(0, 299) == 0) r_test = !r_test;
            if (i % 1000 == 999) do_reset(r_test);
            else step($urandom_range(0, 9) < 3, r_fm, r_test, $urandom_range(0, 399) == 0);
        end

        @(posedge CLK);
        #2;
        n_total++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
